reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-read-port integer register file, successor to the 2R1W file.
//  Adds write-to-read bypass, a per-register busy scoreboard and a sequenced clear engine.
//  Sits in decode/writeback of the pipelined core; the scoreboard feeds hazard detection.
// PARAMETERS
//  XLEN     32  data width in bits
//  NREG     32  number of architectural registers (power of two, >=2); AW = $clog2(NREG)
//  NRD      2   number of read ports (1..4)
//  ZERO_R0  1   1: register 0 reads as 0, ignores writes, is never busy; 0: ordinary register
//  BYPASS   1   1: same-cycle write data forwarded to matching read ports
// PORTS
//  clk       in   1         rising-edge clock
//  rst       in   1         asynchronous active-high reset
//  clr       in   1         pulse: restart clear sweep (all regs -> 0, all busy -> 0)
//  rdy       out  1         1 = sweep finished, file usable
//  ra        in   NRD*AW    read addresses, port i at [i*AW +: AW]
//  rd        out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
//  rbusy     out  NRD       busy bit of register addressed by port i (after bypass rules)
//  we        in   1         write enable
//  wa        in   AW        write address
//  wd        in   XLEN      write data
//  iss       in   1         issue: mark register ia busy (pending producer)
//  ia        in   AW        issued destination address
// BEHAVIOUR
//  Reset (async, rst=1): state=CLR, sweep ptr=0, busy vector=0, rdy=0. Array contents are not
//   reset by rst; the sweep zeroes them. rd outputs are forced to 0 while rdy=0.
//  FSM states: CLR, RUN.
//   CLR: each clk writes 0 to rf[ptr], ptr++; when ptr==NREG-1 is written -> RUN next cycle.
//        Sweep takes exactly NREG cycles after rst deasserts; rdy rises on cycle NREG.
//        we/iss are ignored in CLR; rbusy=0.
//   RUN: rdy=1. clr=1 -> CLR with ptr=0, busy=0 (next edge). clr is ignored while in CLR
//        (sweep not restarted).
//  Read: combinational, zero latency. Port i value:
//   ZERO_R0 && ra_i==0 -> 0; else BYPASS && we && wa==ra_i (and write legal) -> wd; else rf[ra_i].
//  Write: rf[wa] <= wd on clk when we && RUN && !(ZERO_R0 && wa==0).
//  Scoreboard (RUN only), per register r, at clk edge:
//   set  = iss && ia==r; clr_b = we && wa==r.
//   set && clr_b -> busy=1 (new producer wins); set -> 1; clr_b -> 0; else hold.
//   ZERO_R0 -> busy[0] held 0 permanently.
//  rbusy_i: busy[ra_i], except BYPASS && we && wa==ra_i && !(iss && ia==ra_i) -> 0
//   (value is being forwarded this cycle); ZERO_R0 && ra_i==0 -> 0.
//  Multiple read ports addressing the same register return identical data/busy.
//  Reset mid-sweep or mid-run: immediate return to CLR, ptr=0, busy=0, rdy=0.
//  clr and we in the same RUN cycle: the write completes, then sweep zeroes it.
// STRUCTURE
//  Package reg_file_pkg: rf_state_t {RF_CLR, RF_RUN}; default XLEN/NREG constants.
//  Sub-module rf_scoreboard: busy vector with set/clear/priority and NRD lookups (params NREG, NRD,
//   ZERO_R0). Top holds array, sweep FSM/pointer, read muxes and bypass.
// TESTING
//  1 rst pulse, NREG=32 -> rdy=0 for 32 cycles, rdy=1 on cycle 32; all reads 0; busy all 0.
//  2 RUN: we wa=5 wd=0xDEADBEEF, ra0=5 same cycle -> rd0=0xDEADBEEF (BYPASS=1); next cycle still.
//    With BYPASS=0 same-cycle rd0=old value (0).
//  3 we wa=0 wd=0x1234, iss ia=0 (ZERO_R0=1) -> rd of r0=0, rbusy=0 forever.
//  4 iss ia=7 -> next cycle rbusy(ra=7)=1; we wa=7 & iss ia=7 same cycle -> stays busy;
//    we wa=7 alone -> rbusy=0 that cycle (bypass) and 0 after.
//  5 write r3=0xA5, pulse clr -> rdy=0 for 32 cycles, writes during sweep ignored, then r3=0.
//  6 assert rst at sweep cycle 10 and mid-RUN with busy bits set -> rdy=0, busy=0 at once; full
//    32-cycle sweep restarts from ptr 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module : reg_file_pkg
// Brief  : Shared types and defaults for the multi-port register file.
// Rev    : 1.0
// ============================================================================
package reg_file_pkg;

    typedef enum logic [0:0] {
        RF_CLR = 1'b0,
        RF_RUN = 1'b1
    } rf_state_t;

    localparam int RF_XLEN_DEF = 32;
    localparam int RF_NREG_DEF = 32;

endpackage
`default_nettype wire

// File: rtl/reg_file_mp_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : rf_scoreboard
// Brief  : Per-register busy vector with set/clear priority and NRD lookups.
// Rev    : 1.0
// ============================================================================
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int  NREG    = RF_NREG_DEF,
    parameter int  NRD     = 2,
    parameter int  ZERO_R0 = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    input  logic              i_flush,
    input  logic              i_set,
    input  logic [AW-1:0]     i_set_addr,
    input  logic              i_clr,
    input  logic [AW-1:0]     i_clr_addr,
    input  logic [NRD*AW-1:0] i_ra,
    output logic [NRD-1:0]    o_busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // A new producer issued in the same cycle as the old one writes back wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_flush) begin
            w_busy_nxt = '0;
        end else if (i_run) begin
            for (int r = 0; r < NREG; r++) begin
                if (i_set && (i_set_addr == AW'(r))) begin
                    w_busy_nxt[r] = 1'b1;
                end else if (i_clr && (i_clr_addr == AW'(r))) begin
                    w_busy_nxt[r] = 1'b0;
                end
            end
        end
        if (ZERO_R0 != 0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_lookup
        assign o_busy[gi] = r_busy[i_ra[gi*AW +: AW]];
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module : reg_file_mp
// Brief  : Multi-read-port register file with write bypass, busy scoreboard
//          and a sequenced clear sweep.
// Rev    : 1.0
// ============================================================================
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int  XLEN    = RF_XLEN_DEF,
    parameter int  NREG    = RF_NREG_DEF,
    parameter int  NRD     = 2,
    parameter int  ZERO_R0 = 1,
    parameter int  BYPASS  = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                rdy,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                iss,
    input  logic [AW-1:0]       ia
);

    rf_state_t       r_state;
    rf_state_t       w_state_nxt;
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   w_ptr_nxt;
    logic [XLEN-1:0] r_rf [NREG];

    logic            w_run;
    logic            w_wr_legal;
    logic [NRD-1:0]  w_busy_raw;

    assign w_run      = (r_state == RF_RUN);
    assign w_wr_legal = we && w_run && !((ZERO_R0 != 0) && (wa == '0));
    assign rdy        = w_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RF_CLR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            RF_CLR: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == AW'(NREG - 1)) begin
                    w_state_nxt = RF_RUN;
                    w_ptr_nxt   = '0;
                end
            end
            RF_RUN: begin
                if (clr) begin
                    w_state_nxt = RF_CLR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = RF_CLR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Storage has no reset; the sweep is what brings it to a known state.
    always_ff @(posedge clk) begin
        if (r_state == RF_CLR) begin
            r_rf[r_ptr] <= '0;
        end else if (w_wr_legal) begin
            r_rf[wa] <= wd;
        end
    end

    rf_scoreboard #(
        .NREG    (NREG),
        .NRD     (NRD),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_run      (w_run),
        .i_flush    (w_run && clr),
        .i_set      (iss),
        .i_set_addr (ia),
        .i_clr      (we),
        .i_clr_addr (wa),
        .i_ra       (ra),
        .o_busy     (w_busy_raw)
    );

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_is_r0;
        logic          w_fwd;
        logic          w_kill;

        assign w_addr  = ra[gi*AW +: AW];
        assign w_is_r0 = (ZERO_R0 != 0) && (w_addr == '0);
        assign w_fwd   = (BYPASS != 0) && w_wr_legal && (wa == w_addr);
        // A forwarded value is already available, unless it is re-issued now.
        assign w_kill  = (BYPASS != 0) && we && (wa == w_addr) && !(iss && (ia == w_addr));

        assign rd[gi*XLEN +: XLEN] = (!w_run || w_is_r0) ? '0 :
                                     w_fwd               ? wd : r_rf[w_addr];
        assign rbusy[gi] = w_run && !w_is_r0 && !w_kill && w_busy_raw[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module : tb_reg_file_mp
// Brief  : Randomised and directed checks of reg_file_mp against a reference model.
// Rev    : 1.0
// ============================================================================
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  ia;
    logic [9:0]  ra;
    logic        rdy;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic        nb_rdy;
    logic [63:0] nb_rd;
    logic [1:0]  nb_rbusy;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_rf [32];
    bit          m_busy [32];
    bit          m_run;
    int          m_left;

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_R0(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .clr(clr), .rdy(rdy), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we(we), .wa(wa), .wd(wd), .iss(iss), .ia(ia)
    );

    reg_file_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_R0(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .clr(clr), .rdy(nb_rdy), .ra(ra), .rd(nb_rd), .rbusy(nb_rbusy),
        .we(we), .wa(wa), .wd(wd), .iss(iss), .ia(ia)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (!m_run || a == 5'd0) return 32'h0;
        if (byp && we && wa == a) return wd;
        return m_rf[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (!m_run || a == 5'd0) return 1'b0;
        if (byp && we && wa == a && !(iss && ia == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_left = 32;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
    endtask

    // Sweep is modelled as "file unusable for 32 edges, then all zero".
    task automatic model_edge();
        if (!m_run) begin
            m_left--;
            if (m_left == 0) begin
                m_run = 1'b1;
                foreach (m_rf[i]) m_rf[i] = 32'h0;
            end
        end else begin
            if (we && wa != 5'd0) m_rf[wa] = wd;
            if (clr) begin
                m_run  = 1'b0;
                m_left = 32;
                foreach (m_busy[i]) m_busy[i] = 1'b0;
            end else begin
                if (we)  m_busy[wa] = 1'b0;
                if (iss) m_busy[ia] = 1'b1;
                m_busy[0] = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic iwe, input logic [4:0] iwa, input logic [31:0] iwd,
                         input logic iiss, input logic [4:0] iia,
                         input logic [4:0] ira0, input logic [4:0] ira1, input logic iclr);
        we = iwe; wa = iwa; wd = iwd; iss = iiss; ia = iia;
        ra = {ira1, ira0}; clr = iclr;
    endtask

    task automatic drive_rand(input bit allow_clr);
        drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
              allow_clr && ($urandom_range(0, 39) == 0));
    endtask

    task automatic cycle();
        #2;
        chk("rdy",       {31'h0, rdy},         {31'h0, m_run});
        chk("rd0",       rd[31:0],             exp_rd(ra[4:0], 1'b1));
        chk("rd1",       rd[63:32],            exp_rd(ra[9:5], 1'b1));
        chk("rbusy0",    {31'h0, rbusy[0]},    {31'h0, exp_busy(ra[4:0], 1'b1)});
        chk("rbusy1",    {31'h0, rbusy[1]},    {31'h0, exp_busy(ra[9:5], 1'b1)});
        chk("nb_rd0",    nb_rd[31:0],          exp_rd(ra[4:0], 1'b0));
        chk("nb_rbusy0", {31'h0, nb_rbusy[0]}, {31'h0, exp_busy(ra[4:0], 1'b0)});
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic sweep_wait();
        int n = 0;
        while (!rdy && n < 100) begin
            drive_rand(1'b1);
            cycle();
            n++;
        end
        chk("sweep_len", n, 32);
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        #1;
        chk("rst_rdy",   {31'h0, rdy},  32'h0);
        chk("rst_rbusy", {30'h0, rbusy}, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_rdy", {31'h0, rdy}, 32'h0);
        rst = 1'b0;
        sweep_wait();

        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5, 5'd5, 0);
        #1;
        chk("bypass_rd0",  rd[31:0],    32'hDEADBEEF);
        chk("bypass_rd1",  rd[63:32],   32'hDEADBEEF);
        chk("nobypass_rd0", nb_rd[31:0], 32'h0);
        cycle();
        drive(0, 0, 0, 0, 0, 5'd5, 5'd0, 0);
        #1;
        chk("after_wr_rd0", rd[31:0], 32'hDEADBEEF);
        cycle();

        drive(1, 5'd0, 32'h1234, 1, 5'd0, 5'd0, 5'd0, 0);
        #1;
        chk("r0_rd", rd[31:0], 32'h0);
        cycle();
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 0);
        #1;
        chk("r0_rd_after",   rd[31:0],          32'h0);
        chk("r0_busy_after", {31'h0, rbusy[0]}, 32'h0);
        cycle();

        drive(0, 0, 0, 1, 5'd7, 5'd0, 5'd0, 0);
        cycle();
        drive(1, 5'd7, 32'h77, 1, 5'd7, 5'd7, 5'd0, 0);
        #1;
        chk("busy7_set", {31'h0, rbusy[0]}, 32'h1);
        cycle();
        drive(1, 5'd7, 32'h78, 0, 0, 5'd7, 5'd0, 0);
        #1;
        chk("busy7_wr_iss", {31'h0, rbusy[0]}, 32'h0);
        cycle();
        drive(0, 0, 0, 0, 0, 5'd7, 5'd7, 0);
        #1;
        chk("busy7_cleared", {31'h0, rbusy[0]}, 32'h0);
        chk("r7_data",       rd[31:0],          32'h78);
        cycle();

        drive(1, 5'd3, 32'hA5, 0, 0, 5'd3, 5'd0, 0);
        cycle();
        drive(1, 5'd9, 32'h99, 0, 0, 5'd3, 5'd9, 1);
        cycle();
        sweep_wait();
        drive(0, 0, 0, 0, 0, 5'd3, 5'd9, 0);
        #1;
        chk("r3_zeroed", rd[31:0],  32'h0);
        chk("r9_zeroed", rd[63:32], 32'h0);
        cycle();

        drive(0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        for (int i = 0; i < 10; i++) begin
            drive_rand(1'b0);
            cycle();
        end
        do_reset();
        sweep_wait();

        drive(0, 0, 0, 1, 5'd9, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 5'd10, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 5'd9, 5'd10, 0);
        #1;
        chk("busy_before_rst", {30'h0, rbusy}, 32'h3);
        do_reset();
        sweep_wait();
        drive(0, 0, 0, 0, 0, 5'd9, 5'd10, 0);
        #1;
        chk("busy_after_rst", {30'h0, rbusy}, 32'h0);
        cycle();

        for (int i = 0; i < 400; i++) begin
            drive_rand(1'b1);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
